// File: rtl/branch_flag_unit.sv
// rtl/branch_flag_unit.sv - flag register, condition evaluation, PC and return-address stack (optional BRANCH_FLAG_FWD_EN)
module branch_flag_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flag_we,
  input  logic [3:0]  nzcv_in,
  input  logic        carry_in,
  input  logic        br_valid,
  input  logic [1:0]  br_kind,
  input  logic [3:0]  br_cond,
  input  logic [15:0] br_offset,
  output logic [31:0] pc,
  output logic [3:0]  flags,
  output logic        taken,
  output logic [3:0]  ras_count,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int             PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [3:0]     DEPTH_CNT = 4'(RAS_DEPTH);

  localparam logic [1:0] KIND_JUMP = 2'b00;
  localparam logic [1:0] KIND_CALL = 2'b01;
  localparam logic [1:0] KIND_RET  = 2'b10;

  logic [31:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] inc_ptr;

  logic [3:0]  new_flags;
  logic [3:0]  eval_flags;
  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        cond_ok;
  logic [31:0] pc_next;
  logic        do_push;
  logic        do_pop;
  logic        taken_next;
  logic        ovf_next;
  logic        unf_next;

  // The ALU's own C bit is superseded by carry_in.
  logic unused_nzcv_c;
  assign unused_nzcv_c = nzcv_in[1];

  assign new_flags = {nzcv_in[3], nzcv_in[2], carry_in, nzcv_in[0]};

`ifdef BRANCH_FLAG_FWD_EN
  assign eval_flags = flag_we ? new_flags : flags;
`else
  assign eval_flags = flags;
`endif

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = c & !z;
      4'd9:    cond_eval = !c | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Branch resolution: next pc, stack push/pop and the registered status bits.
  always_comb begin
    seq_pc     = pc + 32'd4;
    target     = pc + {{14{br_offset[15]}}, br_offset, 2'b00};
    top_ptr    = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
    inc_ptr    = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    cond_ok    = br_valid & cond_eval(br_cond, eval_flags);
    pc_next    = seq_pc;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    taken_next = 1'b0;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    if (cond_ok) begin
      case (br_kind)
        KIND_JUMP: begin
          pc_next    = target;
          taken_next = 1'b1;
        end
        KIND_CALL: begin
          pc_next    = target;
          do_push    = 1'b1;
          taken_next = 1'b1;
          ovf_next   = (ras_count == DEPTH_CNT);
        end
        KIND_RET: begin
          if (ras_count != 4'd0) begin
            pc_next    = ras_mem[top_ptr];
            do_pop     = 1'b1;
            taken_next = 1'b1;
          end else begin
            unf_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural state; reset beats stall, stall freezes everything but the status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      flags         <= 4'd0;
      taken         <= 1'b0;
      ras_count     <= 4'd0;
      wr_ptr        <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (stall) begin
      taken         <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      taken         <= taken_next;
      ras_overflow  <= ovf_next;
      ras_underflow <= unf_next;
      if (flag_we) flags <= new_flags;
      if (do_push) begin
        wr_ptr <= inc_ptr;
        if (ras_count != DEPTH_CNT) ras_count <= ras_count + 4'd1;
      end else if (do_pop) begin
        wr_ptr    <= top_ptr;
        ras_count <= ras_count - 4'd1;
      end
    end
  end

  // Stack storage; when full the write pointer sits on the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (!reset && !stall && do_push) ras_mem[wr_ptr] <= seq_pc;
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// tb/tb_branch_flag_unit.sv - directed table-driven bench for branch_flag_unit
module tb_branch_flag_unit;

  localparam logic [1:0] J = 2'b00, C = 2'b01, R = 2'b10, X = 2'b11;
  localparam logic [3:0] EQ = 4'd0, NE = 4'd1, VS = 4'd6, HI = 4'd8, GE = 4'd10, LT = 4'd11, AL = 4'd14, NV = 4'd15;

  logic        clk = 1'b0;
  logic        reset, stall, flag_we, carry_in, br_valid;
  logic [3:0]  nzcv_in, br_cond;
  logic [1:0]  br_kind;
  logic [15:0] br_offset;
  logic [31:0] pc;
  logic [3:0]  flags, ras_count;
  logic        taken, ras_overflow, ras_underflow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_flag_unit #(.RESET_PC(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flag_we(flag_we),
    .nzcv_in(nzcv_in), .carry_in(carry_in), .br_valid(br_valid),
    .br_kind(br_kind), .br_cond(br_cond), .br_offset(br_offset),
    .pc(pc), .flags(flags), .taken(taken), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  typedef struct {
    logic        rst, stl, fwe;
    logic [3:0]  nzcv;
    logic        cin, bv;
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [15:0] off;
    logic [31:0] e_pc;
    logic [3:0]  e_fl;
    logic        e_tk;
    logic [3:0]  e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vecs[43];

  function automatic vec_t mk(input logic rst, stl, fwe, input logic [3:0] nzcv, input logic cin, bv,
                              input logic [1:0] kind, input logic [3:0] cond, input logic [15:0] off,
                              input logic [31:0] e_pc, input logic [3:0] e_fl, input logic e_tk,
                              input logic [3:0] e_cnt, input logic e_ovf, e_unf);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fwe = fwe; v.nzcv = nzcv; v.cin = cin; v.bv = bv;
    v.kind = kind; v.cond = cond; v.off = off;
    v.e_pc = e_pc; v.e_fl = e_fl; v.e_tk = e_tk; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] e_pc, input logic [3:0] e_fl, input logic [3:0] e_cnt);
    return mk(0, 0, 0, 4'h0, 0, 0, J, EQ, 16'h0, e_pc, e_fl, 0, e_cnt, 0, 0);
  endfunction

  task automatic apply(input vec_t v, input string name);
    reset = v.rst; stall = v.stl; flag_we = v.fwe; nzcv_in = v.nzcv; carry_in = v.cin;
    br_valid = v.bv; br_kind = v.kind; br_cond = v.cond; br_offset = v.off;
    @(posedge clk);
    #1;
    n_vec++;
    if (pc !== v.e_pc || flags !== v.e_fl || taken !== v.e_tk || ras_count !== v.e_cnt ||
        ras_overflow !== v.e_ovf || ras_underflow !== v.e_unf) begin
      n_bad++;
      $display("FAIL %s: got pc=%h flags=%b taken=%b cnt=%0d ovf=%b unf=%b, want pc=%h flags=%b taken=%b cnt=%0d ovf=%b unf=%b",
               name, pc, flags, taken, ras_count, ras_overflow, ras_underflow,
               v.e_pc, v.e_fl, v.e_tk, v.e_cnt, v.e_ovf, v.e_unf);
    end
  endtask

  initial begin
    // reset and idle counting
    vecs[0]  = mk(1, 0, 0, 4'h0, 0, 0, J, EQ, 16'h0, 32'h100, 4'b0000, 0, 0, 0, 0);
    vecs[1]  = idle(32'h104, 4'b0000, 0);
    vecs[2]  = idle(32'h108, 4'b0000, 0);
    vecs[3]  = idle(32'h10C, 4'b0000, 0);
    // set Z while jumping to 0x200, then EQ/NE jumps back by two words
    vecs[4]  = mk(0, 0, 1, 4'b0100, 0, 1, J, AL, 16'd61,   32'h200, 4'b0100, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 4'b0000, 0, 1, J, EQ, 16'hFFFE, 32'h1F8, 4'b0100, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 4'b0000, 0, 1, J, AL, 16'd2,    32'h200, 4'b0100, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 4'b0000, 0, 1, J, NE, 16'hFFFE, 32'h204, 4'b0100, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 4'b0000, 0, 0, J, EQ, 16'h0,    32'h208, 4'b0000, 0, 0, 0, 0);
    // same-cycle flag write and EQ jump
`ifdef BRANCH_FLAG_FWD_EN
    vecs[9]  = mk(0, 0, 1, 4'b0100, 0, 1, J, EQ, 16'd4,    32'h218, 4'b0100, 1, 0, 0, 0);
`else
    vecs[9]  = mk(0, 0, 1, 4'b0100, 0, 1, J, EQ, 16'd4,    32'h20C, 4'b0100, 0, 0, 0, 0);
`endif
    vecs[10] = mk(1, 0, 0, 4'h0, 0, 0, J, EQ, 16'h0, 32'h100, 4'b0000, 0, 0, 0, 0);
    // nzcv_in bit 1 is ignored, C comes from carry_in
    vecs[11] = mk(0, 0, 1, 4'b1010, 0, 0, J, EQ, 16'h0,    32'h104, 4'b1000, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 4'h0, 0, 1, J, LT, 16'd3,       32'h110, 4'b1000, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 4'h0, 0, 1, J, GE, 16'd3,       32'h114, 4'b1000, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 1, 4'b0001, 1, 0, J, EQ, 16'h0,    32'h118, 4'b0011, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 4'h0, 0, 1, J, HI, 16'd2,       32'h120, 4'b0011, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 4'h0, 0, 1, J, VS, 16'hFFFF,    32'h11C, 4'b0011, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 4'h0, 0, 1, J, NV, 16'd5,       32'h120, 4'b0011, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 4'h0, 0, 1, X, AL, 16'd5,       32'h124, 4'b0011, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 4'h0, 0, 0, J, AL, 16'd5,       32'h128, 4'b0011, 0, 0, 0, 0);
    // five calls into a four-deep stack
    vecs[20] = mk(0, 0, 0, 4'h0, 0, 1, C, AL, 16'd4,       32'h138, 4'b0011, 1, 1, 0, 0);
    vecs[21] = mk(0, 0, 0, 4'h0, 0, 1, C, AL, 16'd4,       32'h148, 4'b0011, 1, 2, 0, 0);
    vecs[22] = mk(0, 0, 0, 4'h0, 0, 1, C, AL, 16'd4,       32'h158, 4'b0011, 1, 3, 0, 0);
    vecs[23] = mk(0, 0, 0, 4'h0, 0, 1, C, AL, 16'd4,       32'h168, 4'b0011, 1, 4, 0, 0);
    vecs[24] = mk(0, 0, 0, 4'h0, 0, 1, C, AL, 16'd4,       32'h178, 4'b0011, 1, 4, 1, 0);
    vecs[25] = idle(32'h17C, 4'b0011, 4);
    // four returns land after calls 5, 4, 3, 2
    vecs[26] = mk(0, 0, 0, 4'h0, 0, 1, R, AL, 16'h0,       32'h16C, 4'b0011, 1, 3, 0, 0);
    vecs[27] = mk(0, 0, 0, 4'h0, 0, 1, R, AL, 16'h0,       32'h15C, 4'b0011, 1, 2, 0, 0);
    vecs[28] = mk(0, 0, 0, 4'h0, 0, 1, R, AL, 16'h0,       32'h14C, 4'b0011, 1, 1, 0, 0);
    vecs[29] = mk(0, 0, 0, 4'h0, 0, 1, R, AL, 16'h0,       32'h13C, 4'b0011, 1, 0, 0, 0);
    // return on empty stack at 0x40
    vecs[30] = mk(0, 0, 0, 4'h0, 0, 1, J, AL, 16'hFFC1,    32'h040, 4'b0011, 1, 0, 0, 0);
    vecs[31] = mk(0, 0, 0, 4'h0, 0, 1, R, AL, 16'h0,       32'h044, 4'b0011, 0, 0, 0, 1);
    vecs[32] = idle(32'h048, 4'b0011, 0);
    // call held by stall for three cycles, then released, then reset while stalled
    vecs[33] = mk(0, 1, 1, 4'b1000, 0, 1, C, AL, 16'd4,    32'h048, 4'b0011, 0, 0, 0, 0);
    vecs[34] = mk(0, 1, 1, 4'b1000, 0, 1, C, AL, 16'd4,    32'h048, 4'b0011, 0, 0, 0, 0);
    vecs[35] = mk(0, 1, 1, 4'b1000, 0, 1, C, AL, 16'd4,    32'h048, 4'b0011, 0, 0, 0, 0);
    vecs[36] = mk(0, 0, 0, 4'h0, 0, 1, C, AL, 16'd4,       32'h058, 4'b0011, 1, 1, 0, 0);
    vecs[37] = mk(1, 1, 0, 4'h0, 0, 1, C, AL, 16'd4,       32'h100, 4'b0000, 0, 0, 0, 0);
    vecs[38] = idle(32'h104, 4'b0000, 0);
    // address wrap on both sequential and target paths
    vecs[39] = mk(0, 0, 0, 4'h0, 0, 1, J, AL, 16'hFFBE,    32'hFFFF_FFFC, 4'b0000, 1, 0, 0, 0);
    vecs[40] = idle(32'h0, 4'b0000, 0);
    vecs[41] = mk(0, 0, 0, 4'h0, 0, 1, J, AL, 16'hFFFF,    32'hFFFF_FFFC, 4'b0000, 1, 0, 0, 0);
    vecs[42] = idle(32'h0, 4'b0000, 0);

    for (int i = 0; i < 43; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // call, failed conditional return keeps the entry, then a real return pops it
    apply(mk(0, 0, 0, 4'h0, 0, 1, C, AL, 16'd4, 32'h010, 4'b0000, 1, 1, 0, 0), "seq_call");
    apply(mk(0, 0, 0, 4'h0, 0, 1, R, NV, 16'h0, 32'h014, 4'b0000, 0, 1, 0, 0), "seq_ret_nv");
    apply(mk(0, 0, 0, 4'h0, 0, 1, R, AL, 16'h0, 32'h004, 4'b0000, 1, 0, 0, 0), "seq_ret_al");
    apply(idle(32'h008, 4'b0000, 0), "seq_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
# branch_flag_unit

Control-flow back end for the single-cycle core. Captures the ALU's N/Z/V flags and carry-out into a flag register and evaluates 4-bit condition codes against it. Owns the program counter and resolves conditional relative jumps, calls and returns through a small return-address stack (RAS). Sits between the ALU flag outputs and the instruction-fetch address.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `RAS_DEPTH`, 4, return-address stack entries (legal 2..8)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  freeze all state this cycle
- `flag_we`  in  1  write flag register this cycle
- `nzcv_in`  in  4  ALU flags {N,Z,C,V}; bit 1 ignored
- `carry_in`  in  1  ALU carry-out, stored as C
- `br_valid`  in  1  branch instruction present this cycle
- `br_kind`  in  2  00 jump, 01 call, 10 return, 11 reserved (treated as no branch)
- `br_cond`  in  4  condition code
- `br_offset`  in  16  signed word offset
- `pc`  out  32  current fetch address
- `flags`  out  4  registered {N,Z,C,V}
- `taken`  out  1  previous update was a taken branch
- `ras_count`  out  4  valid RAS entries
- `ras_overflow`  out  1  one-cycle pulse: call pushed onto full RAS
- `ras_underflow`  out  1  one-cycle pulse: return on empty RAS

## Operation
- Flag write: `flags <= {nzcv_in[3], nzcv_in[2], carry_in, nzcv_in[0]}` when `flag_we`.
- Conditions (N,Z,C,V = evaluation flags): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- `target = pc + {{14{br_offset[15]}}, br_offset, 2'b00}`, modulo 2^32; sequential `pc + 4` wraps 32'hFFFF_FFFC -> 0.
- `cond_ok = br_valid & cond(br_cond)`, with `br_kind` in {00,01,10}.
- Update, each non-stalled cycle:
  - jump & cond_ok: `pc <= target`.
  - call & cond_ok: push `pc + 4`, then `pc <= target`.
  - return & cond_ok & `ras_count != 0`: `pc <= top`, pop.
  - return & cond_ok & empty: `pc <= pc + 4`, no branch, `ras_underflow` pulses.
  - otherwise: `pc <= pc + 4`.
- RAS is circular. A call with `ras_count == RAS_DEPTH` overwrites the oldest entry, leaves count at RAS_DEPTH and pulses `ras_overflow`.
- `taken <= 1` only for jump/call with cond_ok, or a return that pops; otherwise 0.
- Stall: pc, flags, RAS, `ras_count` hold. `taken`, `ras_overflow` and `ras_underflow` clear to 0.

## Timing
- Reset (sync, highest priority, overrides stall): pc=RESET_PC, flags=0, taken=0, ras_count=0, both pulses 0. RAS contents are don't-care.
- Reset asserted mid-sequence discards pending stack state at the next edge. No operation survives it.
- All outputs are registered. Branch decisions are combinational within the cycle; the new pc is visible one cycle after `br_valid`.
- Evaluation flags are the registered `flags`, i.e. the flags as of the previous edge (default build).
- `flag_we` together with a branch in the same cycle: the branch uses the old flags; the flag register updates at the same edge.

## Configuration
- `BRANCH_FLAG_FWD_EN` defined: when `flag_we` is high, condition evaluation uses `{nzcv_in[3], nzcv_in[2], carry_in, nzcv_in[0]}` in the same cycle. This supports compare-and-branch in one instruction.
- `BRANCH_FLAG_FWD_EN` undefined: evaluation always uses the registered `flags`. The flag register update is unchanged in both builds.

## Test plan
- Reset with RESET_PC=32'h100, then 3 idle cycles -> pc 0x100, 0x104, 0x108, 0x10C; flags=0; taken=0.
- flag_we with nzcv_in=4'b0100, carry_in=0; next cycle br_valid, jump, cond EQ, offset -2 at pc=0x200 -> pc=0x1F8, taken=1. Repeat with NE -> pc=0x204, taken=0.
- Same-cycle flag_we with Z=1 and EQ jump, from flags=0 -> default build falls through (pc+4); with BRANCH_FLAG_FWD_EN the branch is taken.
- 5 AL calls with RAS_DEPTH=4 -> ras_count saturates at 4, ras_overflow pulses on the 5th call. 4 AL returns then land on the return addresses of calls 5, 4, 3, 2.
- AL return with ras_count=0 at pc=0x40 -> pc=0x44, taken=0, ras_underflow=1 for exactly one cycle.
- stall held 3 cycles during a pending call -> pc, flags and ras_count frozen, taken=0. Reset asserted while stalled -> pc=RESET_PC at the next edge.
